multicycle_datapath: RTL and testbench

MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

---
 rtl/riscv_pkg.sv | 45 ++++
 rtl/datapath_alu.sv | 21 ++
 rtl/multicycle_datapath.sv | 168 ++++++++++++++++
 tb/tb_multicycle_datapath.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: opcodes, funct fields, FSM states and ALU encoding
// shared by multicycle_datapath and datapath_alu.
package riscv_pkg;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

    function automatic alu_op_e alu_op_of(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic [6:0] f7);
        if (opc == OP_BRANCH || (opc == OP_R && f7 == F7_SUB)) return ALU_SUB;
        if (opc != OP_R && opc != OP_I) return ALU_ADD;
        if (f3 == F3_AND) return ALU_AND;
        if (f3 == F3_OR) return ALU_OR;
        if (f3 == F3_SLT) return ALU_SLT;
        return ALU_ADD;
    endfunction

    // Only the listed subset decodes; anything else halts as illegal.
    function automatic logic is_legal(input logic [6:0] opc, input logic [2:0] f3,
                                      input logic [6:0] f7);
        case (opc)
            OP_R:              return (f3 == F3_ADD && (f7 == F7_BASE || f7 == F7_SUB)) ||
                                      (f7 == F7_BASE && (f3 == F3_SLT || f3 == F3_OR || f3 == F3_AND));
            OP_I:              return f3 == F3_ADD || f3 == F3_OR || f3 == F3_AND;
            OP_LOAD, OP_STORE: return f3 == F3_WORD;
            OP_BRANCH:         return f3 == F3_BEQ;
            OP_SYSTEM:         return 1'b1;
            default:           return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/datapath_alu.sv
// datapath_alu: combinational XLEN-wide ALU (add, sub, and, or, signed slt)
// with a zero flag used for beq.
module datapath_alu import riscv_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] y_o,
    output logic            zero_o
);
    logic lt;

    assign lt     = $signed(a_i) < $signed(b_i);
    assign y_o    = op_i == ALU_SUB ? a_i - b_i :
                    op_i == ALU_AND ? a_i & b_i :
                    op_i == ALU_OR  ? a_i | b_i :
                    op_i == ALU_SLT ? {{(XLEN-1){1'b0}}, lt} :
                                      a_i + b_i;
    assign zero_o = y_o == '0;
endmodule

// File: rtl/multicycle_datapath.sv
// multicycle_datapath: RV32I-subset multicycle core with one shared
// memory port and FETCH/DECODE/EXEC/MEM/WB/HALT sequencing.
module multicycle_datapath import riscv_pkg::*; #(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] pc_out,
    output logic            retire,
    output logic            halted,
    output logic            illegal
);
    localparam int RW = $clog2(NREG);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [XLEN-1:0] alu_q, alu_d, mdr_q, mdr_d;
    logic [31:0]     ir_q, ir_d;
    logic            illegal_q, illegal_d, started_q;
    logic [XLEN-1:0] regs_q [NREG];

    logic [6:0]      opc, f7;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      f3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, rd_a, rd_b, alu_b, alu_y, pc_plus4;
    logic            alu_zero, legal, misaligned;
    alu_op_e         alu_op;

    assign opc = ir_q[6:0];
    assign rd  = ir_q[11:7];
    assign f3  = ir_q[14:12];
    assign rs1 = ir_q[19:15];
    assign rs2 = ir_q[24:20];
    assign f7  = ir_q[31:25];

    assign imm_i = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};

    assign rd_a       = rs1 == '0 ? '0 : regs_q[rs1[RW-1:0]];
    assign rd_b       = rs2 == '0 ? '0 : regs_q[rs2[RW-1:0]];
    assign legal      = is_legal(opc, f3, f7);
    assign alu_op     = alu_op_of(opc, f3, f7);
    assign alu_b      = (opc == OP_R || opc == OP_BRANCH) ? b_q : imm_q;
    assign misaligned = alu_y[1:0] != 2'b00;
    assign pc_plus4   = pc_q + XLEN'(4);

    datapath_alu #(.XLEN(XLEN)) u_alu (
        .op_i   (alu_op),
        .a_i    (a_q),
        .b_i    (alu_b),
        .y_o    (alu_y),
        .zero_o (alu_zero)
    );

    assign pc_out  = pc_q;
    assign halted  = state_q == HALT;
    assign illegal = illegal_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        imm_d     = imm_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        illegal_d = illegal_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;
        mem_wdata = b_q;
        retire    = 1'b0;
        case (state_q)
            // started_q keeps the port idle until the first edge after reset.
            FETCH: begin
                mem_req = started_q;
                if (started_q && mem_ready) begin
                    ir_d    = mem_rdata[31:0];
                    state_d = DECODE;
                end
            end
            DECODE: begin
                a_d       = rd_a;
                b_d       = rd_b;
                imm_d     = opc == OP_STORE ? imm_s : opc == OP_BRANCH ? imm_b : imm_i;
                illegal_d = !legal;
                state_d   = legal ? EXEC : HALT;
            end
            EXEC: begin
                alu_d = alu_y;
                if (opc == OP_BRANCH) begin
                    pc_d    = alu_zero ? pc_q + imm_q : pc_plus4;
                    retire  = 1'b1;
                    state_d = FETCH;
                end else if (opc == OP_SYSTEM) begin
                    state_d = HALT;
                end else if (opc == OP_LOAD || opc == OP_STORE) begin
                    illegal_d = misaligned;
                    state_d   = misaligned ? HALT : MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                mem_req  = 1'b1;
                mem_we   = opc == OP_STORE;
                mem_addr = alu_q;
                if (mem_ready) begin
                    mdr_d   = mem_rdata;
                    retire  = opc == OP_STORE;
                    pc_d    = opc == OP_STORE ? pc_plus4 : pc_q;
                    state_d = opc == OP_STORE ? FETCH : WB;
                end
            end
            WB: begin
                pc_d    = pc_plus4;
                retire  = 1'b1;
                state_d = FETCH;
            end
            HALT: state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            illegal_q <= 1'b0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            alu_q     <= alu_d;
            mdr_q     <= mdr_d;
            illegal_q <= illegal_d;
            started_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (state_q == WB && rd != '0) begin
            regs_q[rd[RW-1:0]] <= opc == OP_LOAD ? mdr_q : alu_q;
        end
    end
endmodule

// File: tb/tb_multicycle_datapath.sv
// tb_multicycle_datapath: directed programs against a wait-state memory model;
// expected retires and stores are queued up front and matched as the core runs.
module tb_multicycle_datapath;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req, mem_we, mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0, pc_out;
    logic        retire, halted, illegal;

    multicycle_datapath dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .pc_out    (pc_out),
        .retire    (retire),
        .halted    (halted),
        .illegal   (illegal)
    );

    initial forever #5 clk = ~clk;

    typedef struct { logic [31:0] pc; int lat; } ret_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } st_t;
    ret_t        rq[$];
    st_t         sq[$];
    logic [31:0] mem [64];
    int          npass = 0, ntotal = 0;
    int          waits = 0;
    logic        hang_writes = 1'b0, ready_in_reset = 1'b0, bad_req = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    localparam logic [6:0] OPI = 7'b0010011, OPL = 7'b0000011;
    localparam logic [31:0] HALT_I = 32'h0000_0073;

    task automatic exp_ret(input logic [31:0] pc, input int lat);
        ret_t e;
        e.pc = pc; e.lat = lat;
        rq.push_back(e);
    endtask
    task automatic exp_st(input logic [31:0] addr, input logic [31:0] data);
        st_t s;
        s.addr = addr; s.data = data;
        sq.push_back(s);
    endtask

    task automatic start_reset();
        @(negedge clk);
        #3 reset = 1'b0;
        rq.delete();
        sq.delete();
        for (int i = 0; i < 64; i++) mem[i] = '0;
    endtask
    task automatic release_reset();
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
    endtask
    task automatic wait_halt(input int max);
        int n = 0;
        while (!halted && n < max) begin
            @(negedge clk);
            #2 n++;
        end
        check("halt_reached", {31'b0, halted}, 32'd1);
    endtask

    // Memory responder: ready after `waits` extra cycles, request must hold meanwhile.
    initial begin
        int          cnt = 0;
        logic [31:0] h_addr = '0, h_wd = '0;
        logic        h_we = 1'b0;
        st_t         s;
        forever begin
            @(negedge clk);
            if (!reset) begin
                mem_ready = ready_in_reset;
                cnt = 0;
            end else if (mem_req) begin
                if (mem_addr == 32'd6) bad_req = 1'b1;
                if (cnt == 0) begin
                    h_addr = mem_addr; h_we = mem_we; h_wd = mem_wdata;
                end else begin
                    check("hold_addr", mem_addr, h_addr);
                    check("hold_we", {31'b0, mem_we}, {31'b0, h_we});
                    check("hold_wdata", mem_wdata, h_wd);
                end
                if (cnt >= waits && !(hang_writes && mem_we)) begin
                    mem_ready = 1'b1;
                    cnt = 0;
                    if (mem_we) begin
                        if (sq.size() == 0) check("store_extra", mem_addr, 32'hFFFF_FFFF);
                        else begin
                            s = sq.pop_front();
                            check("store_addr", mem_addr, s.addr);
                            check("store_data", mem_wdata, s.data);
                        end
                        mem[mem_addr[7:2]] = mem_wdata;
                    end else begin
                        mem_rdata = mem[mem_addr[7:2]];
                    end
                end else begin
                    mem_ready = 1'b0;
                    cnt++;
                end
            end else begin
                mem_ready = 1'b0;
                cnt = 0;
            end
        end
    end

    // Retire monitor: pc and cycles since previous retire (or since reset release).
    initial begin
        int   cyc = 0;
        ret_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) cyc = 0;
            else begin
                cyc++;
                if (retire) begin
                    if (rq.size() == 0) check("retire_extra", {31'b0, retire}, 32'd0);
                    else begin
                        e = rq.pop_front();
                        check("retire_pc", pc_out, e.pc);
                        check("retire_lat", 32'(cyc), 32'(e.lat));
                    end
                    cyc = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Run 1: arithmetic, branches and halt with zero-wait memory.
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[0]  = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI);
        mem[1]  = enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, OPI);
        mem[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
        mem[3]  = enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd4);
        mem[4]  = enc_b(13'd8, 5'd1, 5'd1);
        mem[6]  = enc_b(13'd8, 5'd2, 5'd1);
        mem[7]  = enc_s(12'd128, 5'd3, 5'd0);
        mem[8]  = enc_s(12'd132, 5'd4, 5'd0);
        mem[9]  = enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd6);
        mem[10] = enc_s(12'd136, 5'd6, 5'd0);
        mem[11] = enc_i(12'd15, 5'd2, 3'b111, 5'd7, OPI);
        mem[12] = enc_s(12'd140, 5'd7, 5'd0);
        mem[13] = enc_i(12'h030, 5'd1, 3'b110, 5'd8, OPI);
        mem[14] = enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd9);
        mem[15] = enc_s(12'd144, 5'd8, 5'd0);
        mem[16] = enc_s(12'd148, 5'd9, 5'd0);
        mem[17] = enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd10);
        mem[18] = enc_s(12'd152, 5'd10, 5'd0);
        mem[19] = HALT_I;
        exp_ret(32'h00, 4); exp_ret(32'h04, 4); exp_ret(32'h08, 4); exp_ret(32'h0C, 4);
        exp_ret(32'h10, 3); exp_ret(32'h18, 3);
        for (int i = 7; i <= 18; i++) exp_ret(32'(i * 4), 4);
        exp_st(32'd128, 32'd2); exp_st(32'd132, 32'd1); exp_st(32'd136, 32'hFFFF_FFF8);
        exp_st(32'd140, 32'hD); exp_st(32'd144, 32'h35); exp_st(32'd148, 32'd0);
        exp_st(32'd152, 32'd5);
        ready_in_reset = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_pc", pc_out, 32'd0);
        check("rst_retire", {31'b0, retire}, 32'd0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        check("rst_illegal", {31'b0, illegal}, 32'd0);
        ready_in_reset = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        check("first_req", {31'b0, mem_req}, 32'd1);
        check("first_addr", mem_addr, 32'd0);
        check("first_pc", pc_out, 32'd0);
        wait_halt(300);
        check("halt_illegal", {31'b0, illegal}, 32'd0);
        check("halt_pc", pc_out, 32'h4C);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #2 check("halt_idle", {31'b0, mem_req}, 32'd0);
        end
        check("run1_retires_left", 32'(rq.size()), 32'd0);
        check("run1_stores_left", 32'(sq.size()), 32'd0);

        // Run 2: two wait states everywhere, sw/lw round trip, misaligned lw.
        start_reset();
        waits = 2;
        mem[0] = enc_i(12'd2, 5'd0, 3'b000, 5'd3, OPI);
        mem[1] = enc_b(13'd8, 5'd0, 5'd0);
        mem[3] = enc_s(12'd8, 5'd3, 5'd0);
        mem[4] = enc_i(12'd8, 5'd0, 3'b010, 5'd5, OPL);
        mem[5] = enc_s(12'd12, 5'd5, 5'd0);
        mem[6] = enc_i(12'd6, 5'd0, 3'b010, 5'd6, OPL);
        exp_ret(32'h00, 6); exp_ret(32'h04, 5); exp_ret(32'h0C, 8);
        exp_ret(32'h10, 9); exp_ret(32'h14, 8);
        exp_st(32'd8, 32'd2); exp_st(32'd12, 32'd2);
        bad_req = 1'b0;
        release_reset();
        wait_halt(300);
        check("misalign_illegal", {31'b0, illegal}, 32'd1);
        check("misalign_pc", pc_out, 32'h18);
        repeat (3) @(negedge clk);
        #2 check("misalign_no_req", {31'b0, bad_req | mem_req}, 32'd0);
        check("run2_retires_left", 32'(rq.size()), 32'd0);
        check("run2_stores_left", 32'(sq.size()), 32'd0);

        // Run 3: reset while a store waits for ready.
        start_reset();
        waits = 0;
        hang_writes = 1'b1;
        mem[0] = enc_i(12'd2, 5'd0, 3'b000, 5'd3, OPI);
        mem[1] = enc_s(12'd8, 5'd3, 5'd0);
        exp_ret(32'h00, 4);
        release_reset();
        n = 0;
        while (!(mem_req && mem_we) && n < 40) begin
            @(negedge clk);
            #2 n++;
        end
        check("midmem_req", {31'b0, mem_req && mem_we}, 32'd1);
        check("midmem_addr", mem_addr, 32'd8);
        @(negedge clk);
        #3 reset = 1'b0;
        rq.delete();
        sq.delete();
        #1;
        check("midmem_req_drop", {31'b0, mem_req}, 32'd0);
        check("midmem_we_drop", {31'b0, mem_we}, 32'd0);
        check("midmem_pc", pc_out, 32'd0);
        check("midmem_retire", {31'b0, retire}, 32'd0);
        check("midmem_halted", {31'b0, halted | illegal}, 32'd0);

        // Run 4: x0 stays zero, x3 cleared by the reset, then illegal opcode.
        for (int i = 0; i < 64; i++) mem[i] = '0;
        hang_writes = 1'b0;
        mem[0] = enc_i(12'd7, 5'd0, 3'b000, 5'd0, OPI);
        mem[1] = enc_s(12'd20, 5'd0, 5'd0);
        mem[2] = enc_s(12'd24, 5'd3, 5'd0);
        exp_ret(32'h00, 4); exp_ret(32'h04, 4); exp_ret(32'h08, 4);
        exp_st(32'd20, 32'd0); exp_st(32'd24, 32'd0);
        release_reset();
        wait_halt(100);
        check("opc0_illegal", {31'b0, illegal}, 32'd1);
        check("opc0_pc", pc_out, 32'h0C);
        check("run4_retires_left", 32'(rq.size()), 32'd0);
        check("run4_stores_left", 32'(sq.size()), 32'd0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
